// File: rtl/dram_pkg.sv
// Shared DRAM user-interface definitions: command encodings, burst geometry
// and the write-data FIFO entry layout.
package dram_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    localparam int unsigned BURST_BITS     = 128;
    localparam int unsigned BURST_BYTES    = 16;
    localparam int unsigned DRAM_ADDR_BITS = 27;

    typedef logic [BURST_BITS-1:0] burst_t;

    typedef struct packed {
        logic [BURST_BYTES-1:0] mask;
        burst_t                 data;
    } wdf_entry_t;

endpackage

// File: rtl/mig_app_model_if.sv
// MIG 7-series "app_*" user interface bundle; master is the initiator,
// slave is the memory controller (or this model).
interface mig_app_model_if
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_BITS = DRAM_ADDR_BITS
);
    logic [ADDR_BITS-1:0]   app_addr;
    logic [2:0]             app_cmd;
    logic                   app_en;
    burst_t                 app_wdf_data;
    logic [BURST_BYTES-1:0] app_wdf_mask;
    logic                   app_wdf_end;
    logic                   app_wdf_wren;
    logic                   app_rdy;
    logic                   app_wdf_rdy;
    burst_t                 app_rd_data;
    logic                   app_rd_data_valid;
    logic                   app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_end, app_wdf_wren,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_end, app_wdf_wren,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end
    );

endinterface

// File: rtl/mig_app_wdf_fifo.sv
// Write-data FIFO holding {mask, data} beats until a write command claims them.
// Supports simultaneous push and pop, including when full.
module mig_app_wdf_fifo
    import dram_pkg::*;
#(
    parameter int unsigned WDF_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       pop_i,
    input  wdf_entry_t din_i,
    output wdf_entry_t dout_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int unsigned AW = $clog2(WDF_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(WDF_DEPTH);

    wdf_entry_t    mem_q [WDF_DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mig_app_model.sv
// BRAM-backed responder for the MIG 7-series app_* interface with calibration
// delay and backpressure. Define MIG_APP_MODEL_STALL_EN for LFSR-driven extra stalls.
module mig_app_model
    import dram_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = DRAM_ADDR_BITS,
    parameter int unsigned DEPTH          = 1024,
    parameter int unsigned READ_LATENCY   = 8,
    parameter int unsigned RD_OUTSTANDING = 4,
    parameter int unsigned WDF_DEPTH      = 4,
    parameter int unsigned CALIB_CYCLES   = 64
) (
    input  logic           sclk,
    input  logic           rst_n,
    mig_app_model_if.slave app,
    output logic           init_calib_complete,
    output logic           cmd_err
);
    localparam int unsigned IDX_BITS = $clog2(DEPTH);
    localparam int unsigned CAL_BITS = $clog2(CALIB_CYCLES + 1);
    localparam int unsigned OUT_BITS = $clog2(RD_OUTSTANDING + 1);
    localparam int unsigned PIPE     = READ_LATENCY - 1;

    typedef enum logic {
        WR_IDLE,
        WR_PEND
    } wr_state_e;

    burst_t              mem [DEPTH];
    burst_t              dat_q [PIPE];
    logic [PIPE-1:0]     vld_q, vld_d;
    burst_t              rd_data_q;
    logic                rd_valid_q;

    logic [CAL_BITS-1:0] cal_cnt_q;
    logic                calib_q;
    wr_state_e           wr_state_q;
    logic [IDX_BITS-1:0] pend_idx_q;
    logic [OUT_BITS-1:0] inflight_q, inflight_d;
    logic                err_q;

    logic                stall_cmd, stall_wdf;
    logic                cmd_rdy, wdf_rdy;
    logic                cmd_acc, beat_acc, rd_acc, wr_acc, is_rd, is_wr, bad_cmd;
    logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
    wdf_entry_t          beat, fifo_head, wr_entry;
    logic                have_data, wr_commit;
    logic [IDX_BITS-1:0] cmd_idx, wr_idx;
    logic                unused_addr_hi;

    assign cmd_idx        = app.app_addr[3 +: IDX_BITS];
    assign unused_addr_hi = ^app.app_addr[ADDR_BITS-1:3+IDX_BITS];

`ifdef MIG_APP_MODEL_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_cmd = (lfsr_q[1:0] == 2'b00);
    assign stall_wdf = (lfsr_q[3:2] == 2'b00);
`else
    assign stall_cmd = 1'b0;
    assign stall_wdf = 1'b0;
`endif

    // Ready terms use registered state only, so they never look at app_en.
    assign cmd_rdy  = rst_n && calib_q && (wr_state_q == WR_IDLE)
                      && (inflight_q < OUT_BITS'(RD_OUTSTANDING)) && !stall_cmd;
    assign wdf_rdy  = rst_n && calib_q && !fifo_full && !stall_wdf;

    assign cmd_acc  = app.app_en && cmd_rdy;
    assign beat_acc = app.app_wdf_wren && wdf_rdy;
    assign is_rd    = (app.app_cmd == APP_CMD_READ);
    assign is_wr    = (app.app_cmd == APP_CMD_WRITE);
    assign rd_acc   = cmd_acc && is_rd;
    assign wr_acc   = cmd_acc && is_wr;
    assign bad_cmd  = (cmd_acc && ((app.app_addr[2:0] != 3'b000) || (!is_rd && !is_wr)))
                      || (beat_acc && !app.app_wdf_end);

    // An empty FIFO lets a same-cycle beat pair directly with the write command.
    assign beat      = '{mask: app.app_wdf_mask, data: app.app_wdf_data};
    assign have_data = !fifo_empty || beat_acc;
    assign wr_entry  = fifo_empty ? beat : fifo_head;
    assign wr_commit = rst_n && have_data && (wr_acc || (wr_state_q == WR_PEND));
    assign wr_idx    = (wr_state_q == WR_PEND) ? pend_idx_q : cmd_idx;
    assign fifo_pop  = wr_commit && !fifo_empty;
    assign fifo_push = beat_acc && !(wr_commit && fifo_empty);

    mig_app_wdf_fifo #(
        .WDF_DEPTH (WDF_DEPTH)
    ) u_wdf_fifo (
        .clk_i   (sclk),
        .rst_ni  (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (beat),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Storage and read data path carry no reset so contents survive rst_n.
    always_ff @(posedge sclk) begin
        if (wr_commit) begin
            for (int unsigned b = 0; b < BURST_BYTES; b++) begin
                if (!wr_entry.mask[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_entry.data[8*b +: 8];
                end
            end
        end
        if (rd_acc) begin
            dat_q[0] <= mem[cmd_idx];
        end
        for (int unsigned i = 1; i < PIPE; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_acc;
        for (int unsigned i = 1; i < PIPE; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_comb begin
        inflight_d = inflight_q;
        if (rd_acc && !rd_valid_q) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!rd_acc && rd_valid_q) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            cal_cnt_q  <= '0;
            calib_q    <= 1'b0;
            wr_state_q <= WR_IDLE;
            pend_idx_q <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            vld_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            if (!calib_q) begin
                cal_cnt_q <= cal_cnt_q + 1'b1;
                if (cal_cnt_q == CAL_BITS'(CALIB_CYCLES - 1)) begin
                    calib_q <= 1'b1;
                end
            end

            case (wr_state_q)
                WR_IDLE: begin
                    if (wr_acc && !have_data) begin
                        wr_state_q <= WR_PEND;
                        pend_idx_q <= cmd_idx;
                    end
                end
                WR_PEND: begin
                    if (have_data) begin
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase

            inflight_q <= inflight_d;
            vld_q      <= vld_d;
            rd_valid_q <= vld_q[PIPE-1];
            if (vld_q[PIPE-1]) begin
                rd_data_q <= dat_q[PIPE-1];
            end
            if (bad_cmd) begin
                err_q <= 1'b1;
            end
        end
    end

    assign app.app_rdy           = cmd_rdy;
    assign app.app_wdf_rdy       = wdf_rdy;
    assign app.app_rd_data       = rd_data_q;
    assign app.app_rd_data_valid = rd_valid_q;
    assign app.app_rd_data_end   = rd_valid_q;
    assign init_calib_complete   = calib_q;
    assign cmd_err               = err_q;

endmodule

// File: tb/tb_mig_app_model.sv
// Self-checking bench for mig_app_model: scenario tasks drive the app_* interface,
// a scoreboard queue holds expected read bursts that a monitor pops on valid.
module tb_mig_app_model;
    import dram_pkg::*;

    localparam int unsigned LAT = 8;
    localparam int unsigned CAL = 64;
    localparam burst_t WDATA = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam burst_t W2    = 128'h1111222233334444555566667777888A;
    localparam burst_t W3    = 128'hFEDCBA9876543210F0E1D2C3B4A59687;

    logic sclk = 1'b0;
    logic rst_n;
    logic calib;
    logic cmd_err;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    burst_t exp_q[$];
    int     acc_q[$];
    burst_t mdl [int];
    burst_t mon_e;
    int     mon_t;

    mig_app_model_if #(.ADDR_BITS(27)) app ();

    mig_app_model #(
        .ADDR_BITS      (27),
        .DEPTH          (1024),
        .READ_LATENCY   (LAT),
        .RD_OUTSTANDING (4),
        .WDF_DEPTH      (4),
        .CALIB_CYCLES   (CAL)
    ) dut (
        .sclk                (sclk),
        .rst_n               (rst_n),
        .app                 (app),
        .init_calib_complete (calib),
        .cmd_err             (cmd_err)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc <= cyc + 1;

    // Scoreboard monitor: every valid beat must match the oldest outstanding read.
    always @(negedge sclk) begin
        if (app.app_rd_data_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: valid with no read outstanding, data=%h", app.app_rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = acc_q.pop_front();
                if (app.app_rd_data !== mon_e) begin
                    bad++;
                    $display("FAIL rd_data: got=%h exp=%h", app.app_rd_data, mon_e);
                end
                total++;
                if (cyc - mon_t != int'(LAT)) begin
                    bad++;
                    $display("FAIL rd_latency: got=%0d exp=%0d", cyc - mon_t, LAT);
                end
                total++;
                if (app.app_rd_data_end !== 1'b1) begin
                    bad++;
                    $display("FAIL rd_end: got=%b exp=1", app.app_rd_data_end);
                end
            end
        end
    end

    function automatic int idx_of(input logic [26:0] a);
        return int'(a[12:3]);
    endfunction

    function automatic burst_t mdl_rd(input int i);
        return mdl.exists(i) ? mdl[i] : 'x;
    endfunction

    function automatic void mdl_wr(input int i, input burst_t d, input logic [15:0] m);
        burst_t w = mdl_rd(i);
        for (int b = 0; b < 16; b++) begin
            if (!m[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mdl[i] = w;
    endfunction

    // Present a command (optionally with a same-cycle beat) until accepted.
    task automatic issue(input logic [2:0] cmd, input logic [26:0] addr, input bit beat,
                         input bit model_wr, input burst_t d, input logic [15:0] m);
        bit done = 1'b0;
        app.app_en       = 1'b1;
        app.app_cmd      = cmd;
        app.app_addr     = addr;
        app.app_wdf_wren = beat;
        app.app_wdf_data = d;
        app.app_wdf_mask = m;
        app.app_wdf_end  = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge sclk);
            if (app.app_rdy === 1'b1 && (!beat || app.app_wdf_rdy === 1'b1)) begin
                done = 1'b1;
                if (cmd == APP_CMD_READ) begin
                    exp_q.push_back(mdl_rd(idx_of(addr)));
                    acc_q.push_back(cyc);
                end else if (cmd == APP_CMD_WRITE && model_wr) begin
                    mdl_wr(idx_of(addr), d, m);
                end
            end
            @(posedge sclk);
            #1;
        end
        app.app_en       = 1'b0;
        app.app_wdf_wren = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL issue_timeout: cmd=%0d addr=%h got=not_accepted exp=accepted", cmd, addr);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge sclk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got=%0d reads outstanding exp=0", exp_q.size());
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic wait_calib();
        bit seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge sclk);
            if (calib === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL calib_timeout: got=0 exp=1");
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        total += 7;
        if (app.app_rdy !== 1'b0) begin bad++; $display("FAIL rst_app_rdy: got=%b exp=0", app.app_rdy); end
        if (app.app_wdf_rdy !== 1'b0) begin bad++; $display("FAIL rst_wdf_rdy: got=%b exp=0", app.app_wdf_rdy); end
        if (app.app_rd_data !== '0) begin bad++; $display("FAIL rst_rd_data: got=%h exp=0", app.app_rd_data); end
        if (app.app_rd_data_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got=%b exp=0", app.app_rd_data_valid); end
        if (app.app_rd_data_end !== 1'b0) begin bad++; $display("FAIL rst_rd_end: got=%b exp=0", app.app_rd_data_end); end
        if (calib !== 1'b0) begin bad++; $display("FAIL rst_calib: got=%b exp=0", calib); end
        if (cmd_err !== 1'b0) begin bad++; $display("FAIL rst_cmd_err: got=%b exp=0", cmd_err); end
        @(posedge sclk);
        #1;
    endtask

    task automatic test_calib();
        rst_n = 1'b1;
        for (int k = 1; k <= int'(CAL); k++) begin
            @(posedge sclk);
            @(negedge sclk);
            total += 2;
            if (calib !== (k == int'(CAL))) begin
                bad++;
                $display("FAIL calib_edge: cycle=%0d got=%b exp=%b", k, calib, k == int'(CAL));
            end
            if (app.app_rdy !== (k == int'(CAL))) begin
                bad++;
                $display("FAIL calib_rdy: cycle=%0d got=%b exp=%b", k, app.app_rdy, k == int'(CAL));
            end
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic test_write_read();
        issue(APP_CMD_WRITE, 27'h40, 1'b1, 1'b1, WDATA, 16'h0000);
        issue(APP_CMD_READ, 27'h40, 1'b0, 1'b0, '0, 16'h0000);
        wait_drain();
        @(negedge sclk);
        total++;
        if (app.app_rd_data !== WDATA || app.app_rd_data_valid !== 1'b0) begin
            bad++;
            $display("FAIL rd_hold: got=%h/%b exp=%h/0", app.app_rd_data, app.app_rd_data_valid, WDATA);
        end
        @(posedge sclk);
        #1;
    endtask

    task automatic test_ordering();
        issue(APP_CMD_READ, 27'h40, 1'b0, 1'b0, '0, 16'h0000);
        issue(APP_CMD_WRITE, 27'h40, 1'b1, 1'b1, W2, 16'h0000);
        issue(APP_CMD_READ, 27'h40, 1'b0, 1'b0, '0, 16'h0000);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        bit seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(APP_CMD_WRITE, 27'(i * 8), 1'b1, 1'b1, {4{32'(32'hA000_0000 + i)}}, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            issue(APP_CMD_READ, 27'(i * 8), 1'b0, 1'b0, '0, 16'h0000);
        end
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge sclk);
            if (app.app_rd_data_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                total++;
                if (app.app_rdy !== 1'b0) begin
                    bad++;
                    $display("FAIL rdy_outstanding: got=%b exp=0", app.app_rdy);
                end
            end
        end
        total++;
        if (!seen) begin bad++; $display("FAIL first_return: got=none exp=valid"); end
        @(negedge sclk);
        total++;
        if (app.app_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rdy_after_return: got=%b exp=1", app.app_rdy);
        end
        @(posedge sclk);
        #1;
        wait_drain();
    endtask

    task automatic test_fifo_full();
        for (int i = 0; i < 5; i++) begin
            app.app_wdf_wren = 1'b1;
            app.app_wdf_end  = 1'b1;
            app.app_wdf_mask = 16'h0000;
            app.app_wdf_data = (i < 4) ? {4{32'(32'hF000_0000 + i)}} : {4{32'hDEAD_BEEF}};
            @(negedge sclk);
            total++;
            if (app.app_wdf_rdy !== (i < 4)) begin
                bad++;
                $display("FAIL wdf_rdy_fill: beat=%0d got=%b exp=%b", i, app.app_wdf_rdy, i < 4);
            end
            @(posedge sclk);
            #1;
        end
        app.app_wdf_wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(APP_CMD_WRITE, 27'(27'h100 + i * 8), 1'b0, 1'b1, {4{32'(32'hF000_0000 + i)}}, 16'h0000);
        end
        for (int i = 0; i < 4; i++) begin
            issue(APP_CMD_READ, 27'(27'h100 + i * 8), 1'b0, 1'b0, '0, 16'h0000);
        end
        wait_drain();
    endtask

    task automatic test_pending_write();
        issue(APP_CMD_WRITE, 27'h40, 1'b0, 1'b0, W3, 16'h00FF);
        repeat (3) begin
            @(negedge sclk);
            total++;
            if (app.app_rdy !== 1'b0) begin
                bad++;
                $display("FAIL rdy_pending: got=%b exp=0", app.app_rdy);
            end
            @(posedge sclk);
            #1;
        end
        app.app_wdf_wren = 1'b1;
        app.app_wdf_data = W3;
        app.app_wdf_mask = 16'h00FF;
        app.app_wdf_end  = 1'b1;
        @(negedge sclk);
        total++;
        if (app.app_wdf_rdy !== 1'b1) begin
            bad++;
            $display("FAIL wdf_rdy_pending: got=%b exp=1", app.app_wdf_rdy);
        end
        @(posedge sclk);
        #1;
        app.app_wdf_wren = 1'b0;
        mdl_wr(idx_of(27'h40), W3, 16'h00FF);
        @(negedge sclk);
        total++;
        if (app.app_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rdy_after_commit: got=%b exp=1", app.app_rdy);
        end
        @(posedge sclk);
        #1;
        issue(APP_CMD_READ, 27'h40, 1'b0, 1'b0, '0, 16'h0000);
        wait_drain();
    endtask

    task automatic test_cmd_err();
        @(negedge sclk);
        total++;
        if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_clear: got=%b exp=0", cmd_err); end
        @(posedge sclk);
        #1;
        issue(APP_CMD_READ, 27'h43, 1'b0, 1'b0, '0, 16'h0000);
        @(negedge sclk);
        total++;
        if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_misaligned: got=%b exp=1", cmd_err); end
        @(posedge sclk);
        #1;
        wait_drain();
        @(negedge sclk);
        total++;
        if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got=%b exp=1", cmd_err); end
        @(posedge sclk);
        #1;
        rst_n = 1'b0;
        @(posedge sclk);
        #1;
        rst_n = 1'b1;
        @(negedge sclk);
        total++;
        if (cmd_err !== 1'b0) begin bad++; $display("FAIL err_reset: got=%b exp=0", cmd_err); end
        @(posedge sclk);
        #1;
        wait_calib();
        issue(3'b010, 27'h48, 1'b0, 1'b0, '0, 16'h0000);
        @(negedge sclk);
        total++;
        if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_unknown_cmd: got=%b exp=1", cmd_err); end
        repeat (12) @(posedge sclk);
        @(negedge sclk);
        total++;
        if (cmd_err !== 1'b1) begin bad++; $display("FAIL err_hold: got=%b exp=1", cmd_err); end
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        issue(APP_CMD_READ, 27'h00, 1'b0, 1'b0, '0, 16'h0000);
        issue(APP_CMD_READ, 27'h08, 1'b0, 1'b0, '0, 16'h0000);
        issue(APP_CMD_READ, 27'h40, 1'b0, 1'b0, '0, 16'h0000);
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        @(posedge sclk);
        #1;
        rst_n = 1'b1;
        @(negedge sclk);
        total++;
        if (calib !== 1'b0) begin bad++; $display("FAIL calib_restart: got=%b exp=0", calib); end
        repeat (20) begin
            @(negedge sclk);
            if (app.app_rd_data_valid === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL flushed_reads: got=%0d pulses exp=0", pulses); end
        @(posedge sclk);
        #1;
        wait_calib();
        issue(APP_CMD_READ, 27'h40, 1'b0, 1'b0, '0, 16'h0000);
        wait_drain();
    endtask

    initial begin
        rst_n            = 1'b0;
        app.app_en       = 1'b0;
        app.app_cmd      = 3'b000;
        app.app_addr     = '0;
        app.app_wdf_wren = 1'b0;
        app.app_wdf_data = '0;
        app.app_wdf_mask = '0;
        app.app_wdf_end  = 1'b0;
        test_reset();
        test_calib();
        test_write_read();
        test_ordering();
        test_back_to_back();
        test_fifo_full();
        test_pending_write();
        test_cmd_err();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mig_app_model.md
Name: mig_app_model

Overview:
- Synthesizable responder for the MIG 7-series user ("app_*") interface, backed by on-chip BRAM.
- Stands in for mig_7series_0 behind the DRAM cache-line wrapper in simulation and in DDR-less FPGA builds.
- Accepts read and write commands, stores 128-bit bursts, and returns read data in order after a fixed latency.
- Emulates calibration delay and app_rdy/app_wdf_rdy backpressure.

Parameters:
- ADDR_BITS, 27, width of app_addr in 16-bit-word units.
- DEPTH, 1024, number of 128-bit bursts stored; power of 2.
- READ_LATENCY, 8, cycles from read-command acceptance to app_rd_data_valid; minimum 2.
- RD_OUTSTANDING, 4, maximum in-flight reads before app_rdy drops.
- WDF_DEPTH, 4, write-data FIFO entries; power of 2.
- CALIB_CYCLES, 64, cycles after reset release before init_calib_complete rises.

Ports:
- sclk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset: synchronous, active-low.
- app_addr  in  ADDR_BITS  command address, 16-bit-word units.
- app_cmd  in  3  3'b000 write, 3'b001 read.
- app_en  in  1  command valid.
- app_wdf_data  in  128  write burst.
- app_wdf_mask  in  16  1 = byte not written.
- app_wdf_end  in  1  last beat; every beat is last.
- app_wdf_wren  in  1  write data valid.
- app_rdy  out  1  command accept.
- app_wdf_rdy  out  1  write data accept.
- app_rd_data  out  128  read burst.
- app_rd_data_valid  out  1  read burst valid.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  model ready.
- cmd_err  out  1  sticky error flag: misaligned address, unknown app_cmd, or wren with app_wdf_end=0.

Behaviour:
- Reset values: app_rdy=0, app_wdf_rdy=0, app_rd_data=0, app_rd_data_valid=0, app_rd_data_end=0, init_calib_complete=0, cmd_err=0.
- Reset flushes the write-data FIFO, pending write and read pipeline. Memory contents are preserved.
- Reset mid-operation drops in-flight reads with no valid pulse and restarts the calibration counter.
- Calibration: a counter runs from reset release. init_calib_complete=1 on cycle CALIB_CYCLES and stays high.
- Before calibration completes, app_rdy=0 and app_wdf_rdy=0.
- Burst index = app_addr[ADDR_BITS-1:3] mod DEPTH.
- app_addr[2:0] != 0 sets cmd_err; the low bits are ignored.
- Write data: a beat is accepted when app_wdf_wren && app_wdf_rdy, and is pushed to the write-data FIFO.
- app_wdf_rdy = calibrated && FIFO not full.
- Command handshake: a command is accepted when app_en && app_rdy. At most one command per cycle.
- app_rdy = calibrated && no pending write && in-flight reads < RD_OUTSTANDING. app_rdy never depends on app_en in the same cycle.
- Write command:
  - Pairs with the FIFO head. If the FIFO is empty, it pairs with the same-cycle accepted beat (bypass).
  - Memory is updated at the clock edge of acceptance, byte-masked.
  - If no data is available, address is latched as the pending write and app_rdy drops. Commit happens on the first cycle data is available, then app_rdy returns next cycle.
- Read command:
  - Memory is read at acceptance and the word enters the READ_LATENCY-deep pipeline.
  - Output: app_rd_data_valid=1 exactly READ_LATENCY cycles later, in acceptance order, one beat per command, app_rd_data_end=1.
  - app_rd_data holds its last value when not valid.
- Ordering: memory is written at write acceptance and read at read acceptance, which gives sequential consistency.
  - A read accepted the cycle after a write to the same index returns the new data.
  - A read issued earlier returns the old data.
- In-flight counter: increments on read accept and decrements on valid output. Simultaneous increment and decrement leaves it unchanged.
- Unknown app_cmd: accepted, no effect, sets cmd_err.
- Write data with no write command never committed: stays in the FIFO.
- FIFO full: app_wdf_rdy=0. Data offered while app_wdf_rdy=0 is ignored.

Optional Feature:
- Macro MIG_APP_MODEL_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1, advancing every cycle) gates the ready outputs.
  - app_rdy is additionally forced low when lfsr[1:0]==2'b00.
  - app_wdf_rdy is additionally forced low when lfsr[3:2]==2'b00.
  - Used to stress the initiator's retry logic.
- Undefined: no extra stalls; behaviour exactly as above.

Decomposition:
- Shared package dram_pkg:
  - APP_CMD_READ=3'b001, APP_CMD_WRITE=3'b000.
  - BURST_BITS=128, BURST_BYTES=16, DRAM_ADDR_BITS=27.
  - typedef burst_t (logic [127:0]).
- Sub-module mig_app_wdf_fifo: synchronous FIFO of {mask, data}, parameterized WDF_DEPTH, with full/empty, push/pop and same-cycle push+pop when full.
- Memory, read pipeline and control stay in mig_app_model.

Test Plan:
- Reset, then hold: init_calib_complete rises exactly 64 cycles after rst_n=1; app_rdy=0 before that, 1 on that cycle.
- Write 128'h0123…CDEF at app_addr 27'h40 (cmd+wren same cycle), then read 27'h40 -> app_rd_data_valid exactly 8 cycles after read accept, data 128'h0123…CDEF, app_rd_data_end=1.
- Four consecutive reads at 27'h0, 27'h8, 27'h10, 27'h18 -> app_rdy low until the first returns; data returns in issue order.
- Write command with no data -> app_rdy=0. Data with mask 16'h00FF supplied 3 cycles later -> only upper 8 bytes change; app_rdy=1 the following cycle.
- app_addr 27'h43 or app_cmd 3'b010 -> cmd_err=1 and stays 1 until rst_n=0.
- rst_n=0 for 1 cycle with 3 reads in flight -> no app_rd_data_valid pulses afterward; a later read of a previously written address still returns the stored data.
